// File: rtl/bv_shift_inv_solver.sv
// Sequential inverse solver for shift(x, s) == t over ashr/lshr/shl.
// Builds a candidate by undoing the shift, then re-applies the shift to confirm it.
module bv_shift_inv_solver #(
   parameter int unsigned W     = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_mode,
   input  logic [W-1:0]     in_s,
   input  logic [W-1:0]     in_t,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_x,
   output logic             out_found,
   output logic             busy,
   output logic [CNT_W-1:0] solved_count
);

   localparam int unsigned CW = $clog2(W + 1);
   localparam logic [W:0]    W_VAL = (W + 1)'(W);
   localparam logic [CW-1:0] K_MAX = CW'(W);

   localparam logic [1:0] MODE_ASHR = 2'd0;
   localparam logic [1:0] MODE_LSHR = 2'd1;
   localparam logic [1:0] MODE_SHL  = 2'd2;
   localparam logic [1:0] MODE_RSVD = 2'd3;

   typedef enum logic [2:0] {StIdle, StFwd, StBack, StCmp, StDone} state_t;

   state_t           state_q, state_d;
   logic [1:0]       mode_q, mode_d;
   logic [W-1:0]     t_q, t_d;
   logic [W-1:0]     acc_q, acc_d;
   logic [W-1:0]     cand_q, cand_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CW-1:0]    kb_q, kb_d;
   logic [W-1:0]     x_q, x_d;
   logic             found_q, found_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic          s_ge_w;
   logic [CW-1:0] k, kf, kb;
   logic          hit;

   // Full-width compare so large s never aliases into a small shift count.
   assign s_ge_w = ({1'b0, in_s} >= W_VAL);
   assign k      = s_ge_w ? K_MAX : in_s[CW-1:0];
   assign kf     = ((in_mode == MODE_RSVD) || ((in_mode == MODE_ASHR) && s_ge_w)) ? '0 : k;
   assign kb     = (in_mode == MODE_RSVD) ? '0 : k;
   assign hit    = (acc_q == t_q) && (mode_q != MODE_RSVD);

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      t_d     = t_q;
      acc_d   = acc_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      kb_d    = kb_q;
      x_d     = x_q;
      found_d = found_q;
      count_d = count_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               mode_d  = in_mode;
               t_d     = in_t;
               acc_d   = in_t;
               cnt_d   = kf;
               kb_d    = kb;
               state_d = StFwd;
            end
         end
         StFwd: begin
            if (cnt_q == '0) begin
               cand_d  = acc_q;
               cnt_d   = kb_q;
               state_d = StBack;
            end else begin
               acc_d = (mode_q == MODE_SHL) ? (acc_q >> 1) : (acc_q << 1);
               cnt_d = cnt_q - CW'(1);
            end
         end
         StBack: begin
            if (cnt_q == '0) begin
               state_d = StCmp;
            end else begin
               case (mode_q)
                  MODE_ASHR: acc_d = {acc_q[W-1], acc_q[W-1:1]};
                  MODE_LSHR: acc_d = acc_q >> 1;
                  default:   acc_d = acc_q << 1;
               endcase
               cnt_d = cnt_q - CW'(1);
            end
         end
         StCmp: begin
            found_d = hit;
            x_d     = hit ? cand_q : '0;
            state_d = StDone;
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
               if (found_q && (count_q != '1)) begin
                  count_d = count_q + CNT_W'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         mode_q  <= '0;
         t_q     <= '0;
         acc_q   <= '0;
         cand_q  <= '0;
         cnt_q   <= '0;
         kb_q    <= '0;
         x_q     <= '0;
         found_q <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         t_q     <= t_d;
         acc_q   <= acc_d;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
         kb_q    <= kb_d;
         x_q     <= x_d;
         found_q <= found_d;
         count_q <= count_d;
      end
   end

   assign in_ready     = (state_q == StIdle);
   assign busy         = (state_q != StIdle);
   assign out_valid    = (state_q == StDone);
   assign out_x        = x_q;
   assign out_found    = found_q;
   assign solved_count = count_q;

endmodule

// File: tb/tb_bv_shift_inv_solver.sv
// Directed bench for bv_shift_inv_solver: solve table, backpressure, async reset, saturation.
module tb_bv_shift_inv_solver;

   localparam int unsigned W     = 8;
   localparam int unsigned CNT_W = 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [1:0]       in_mode = '0;
   logic [W-1:0]     in_s = '0;
   logic [W-1:0]     in_t = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [W-1:0]     out_x;
   logic             out_found;
   logic             busy;
   logic [CNT_W-1:0] solved_count;

   int vectors = 0;
   int miscompares = 0;
   logic [CNT_W-1:0] exp_cnt = '0;

   typedef struct packed {
      logic [1:0]   m;
      logic [W-1:0] s;
      logic [W-1:0] t;
      logic [W-1:0] x;
      logic         f;
      logic [5:0]   lat;
   } vec_t;

   bv_shift_inv_solver #(.W(W), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_mode      (in_mode),
      .in_s         (in_s),
      .in_t         (in_t),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_x        (out_x),
      .out_found    (out_found),
      .busy         (busy),
      .solved_count (solved_count)
   );

   always #5 clk = ~clk;

   // Issue one request and count edges from the accept edge until out_valid.
   task automatic do_req(input logic [1:0] m, input logic [W-1:0] s, input logic [W-1:0] t,
                         output logic [W-1:0] x, output logic f, output int lat);
      @(negedge clk);
      in_valid = 1'b1;
      in_mode  = m;
      in_s     = s;
      in_t     = t;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_s     = ~s;
      in_t     = ~t;
      lat      = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      x = out_x;
      f = out_found;
   endtask

   task automatic release_out(input logic f);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      if (f && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
   endtask

   task automatic test_reset();
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++; $display("FAIL reset in_ready: got %b want 1", in_ready);
      end
      vectors++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         miscompares++; $display("FAIL reset valid/busy: got %b/%b want 0/0", out_valid, busy);
      end
      vectors++;
      if (out_x !== '0 || out_found !== 1'b0) begin
         miscompares++; $display("FAIL reset x/found: got %h/%b want 00/0", out_x, out_found);
      end
      vectors++;
      if (solved_count !== '0) begin
         miscompares++; $display("FAIL reset count: got %0d want 0", solved_count);
      end
   endtask

   task automatic test_modes();
      vec_t tbl [10];
      logic [W-1:0] x;
      logic f;
      int lat;
      tbl[0] = '{2'd0, 8'd2,   8'hF0, 8'hC0, 1'b1, 6'd7};
      tbl[1] = '{2'd0, 8'd2,   8'h70, 8'h00, 1'b0, 6'd7};
      tbl[2] = '{2'd0, 8'd200, 8'hFF, 8'hFF, 1'b1, 6'd11};
      tbl[3] = '{2'd0, 8'd200, 8'h80, 8'h00, 1'b0, 6'd11};
      tbl[4] = '{2'd2, 8'd3,   8'h28, 8'h05, 1'b1, 6'd9};
      tbl[5] = '{2'd2, 8'd3,   8'h2C, 8'h00, 1'b0, 6'd9};
      tbl[6] = '{2'd2, 8'd9,   8'h00, 8'h00, 1'b1, 6'd19};
      tbl[7] = '{2'd1, 8'd4,   8'h0A, 8'hA0, 1'b1, 6'd11};
      tbl[8] = '{2'd1, 8'd4,   8'h1A, 8'h00, 1'b0, 6'd11};
      tbl[9] = '{2'd3, 8'd0,   8'h55, 8'h00, 1'b0, 6'd3};
      for (int i = 0; i < 10; i++) begin
         do_req(tbl[i].m, tbl[i].s, tbl[i].t, x, f, lat);
         vectors++;
         if (x !== tbl[i].x) begin
            miscompares++; $display("FAIL modes[%0d] out_x: got %h want %h", i, x, tbl[i].x);
         end
         vectors++;
         if (f !== tbl[i].f) begin
            miscompares++; $display("FAIL modes[%0d] found: got %b want %b", i, f, tbl[i].f);
         end
         vectors++;
         if (lat != int'(tbl[i].lat)) begin
            miscompares++;
            $display("FAIL modes[%0d] latency: got %0d want %0d", i, lat, tbl[i].lat);
         end
         release_out(tbl[i].f);
         vectors++;
         if (solved_count !== exp_cnt) begin
            miscompares++;
            $display("FAIL modes[%0d] count: got %0d want %0d", i, solved_count, exp_cnt);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] x;
      logic f;
      int lat;
      do_req(2'd0, 8'd1, 8'hFF, x, f, lat);
      vectors++;
      if (x !== 8'hFE || f !== 1'b1 || lat != 5) begin
         miscompares++;
         $display("FAIL bp result: got x=%h f=%b lat=%0d want FE/1/5", x, f, lat);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_mode  = 2'd0;
         in_s     = 8'd0;
         in_t     = 8'h11;
         @(posedge clk);
         #1;
         vectors++;
         if (out_valid !== 1'b1 || out_x !== 8'hFE || out_found !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp hold[%0d]: got v=%b x=%h f=%b rdy=%b want 1/FE/1/0",
                     i, out_valid, out_x, out_found, in_ready);
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      release_out(1'b1);
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL bp release: got v=%b rdy=%b want 0/1", out_valid, in_ready);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (busy !== 1'b0 || solved_count !== exp_cnt) begin
         miscompares++;
         $display("FAIL bp after: got busy=%b cnt=%0d want 0/%0d", busy, solved_count, exp_cnt);
      end
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] x;
      logic f;
      int lat;
      @(negedge clk);
      in_valid = 1'b1;
      in_mode  = 2'd0;
      in_s     = 8'd6;
      in_t     = 8'h12;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      exp_cnt = '0;
      vectors++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL midrst flags: got v=%b busy=%b rdy=%b want 0/0/1",
                  out_valid, busy, in_ready);
      end
      vectors++;
      if (solved_count !== '0) begin
         miscompares++; $display("FAIL midrst count: got %0d want 0", solved_count);
      end
      @(negedge clk);
      rst_n = 1'b1;
      do_req(2'd0, 8'd1, 8'hFF, x, f, lat);
      vectors++;
      if (x !== 8'hFE || f !== 1'b1 || lat != 5) begin
         miscompares++;
         $display("FAIL midrst fresh: got x=%h f=%b lat=%0d want FE/1/5", x, f, lat);
      end
      release_out(1'b1);
      vectors++;
      if (solved_count !== exp_cnt) begin
         miscompares++;
         $display("FAIL midrst count2: got %0d want %0d", solved_count, exp_cnt);
      end
   endtask

   // s=0 solves trivially; enough of them drive the narrow counter into saturation.
   task automatic test_saturation();
      logic [W-1:0] x;
      logic f;
      int lat;
      for (int i = 0; i < 8; i++) begin
         do_req(2'(i % 3), 8'd0, 8'(8'h30 + i), x, f, lat);
         vectors++;
         if (x !== 8'(8'h30 + i) || f !== 1'b1 || lat != 3) begin
            miscompares++;
            $display("FAIL sat[%0d] result: got x=%h f=%b lat=%0d want %h/1/3",
                     i, x, f, lat, 8'(8'h30 + i));
         end
         release_out(1'b1);
         vectors++;
         if (solved_count !== exp_cnt) begin
            miscompares++;
            $display("FAIL sat[%0d] count: got %0d want %0d", i, solved_count, exp_cnt);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      test_modes();
      test_backpressure();
      test_reset_mid();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
